core_frame_rx: RTL

- Core-side receiver for the scheduler's frame broadcast bus. One instance per core.
- Accepts 16-bit beats of 256-bit frames addressed to its core, writes them into a local program buffer, then launches the core.
- Drives the `core_reading` / `core_ready` handshakes that the scheduler consumes. The scheduler reduces `core_reading` across cores and concatenates `core_ready` into its 16-bit vector.
- Exposes a read port so the core pipeline can fetch instructions.

---
 rtl/sched_pkg.sv | 12 +
 rtl/core_imem.sv | 29 ++
 rtl/core_frame_rx.sv | 101 ++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Constants and types shared by the scheduler and the core-side frame receivers.
package sched_pkg;
  localparam int BUS_TO_CORE = 16;
  localparam int FRAME_SIZE  = 256;
  localparam int BEATS       = FRAME_SIZE / BUS_TO_CORE;
  localparam int CORE_NUM    = 16;

  typedef logic [BUS_TO_CORE-1:0] frame_beat_t;
  typedef logic [CORE_NUM-1:0]    core_mask_t;

  typedef enum logic [1:0] {IDLE, RECV, LAUNCH, RUN} rx_state_t;
endpackage

// File: rtl/core_imem.sv
// Core program buffer: one write port, one registered read port.
// Latency: read data 1 cycle after raddr; a same-address write returns old data.
// Backpressure: none, both ports accept every cycle.
module core_imem
  import sched_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = BUS_TO_CORE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end
endmodule

// File: rtl/core_frame_rx.sv
// Receives broadcast frame beats for this core into the program buffer, then launches the core.
// Latency: prog_start pulses the cycle after the last beat edge; imem_rdata is 1 cycle behind imem_raddr.
// Backpressure: core_reading drops from launch until core_done; beats offered meanwhile are not taken.
module core_frame_rx #(
  parameter int CORE_ID     = 0,
  parameter int CORE_NUM    = sched_pkg::CORE_NUM,
  parameter int BUS_TO_CORE = sched_pkg::BUS_TO_CORE,
  parameter int FRAME_SIZE  = sched_pkg::FRAME_SIZE,
  parameter int IMEM_DEPTH  = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_valid,
  input  logic [BUS_TO_CORE-1:0]        frame_data,
  input  logic [CORE_NUM-1:0]           frame_mask,
  input  logic                          frame_last,
  output logic                          core_reading,
  output logic                          core_ready,
  output logic                          prog_start,
  output logic [$clog2(IMEM_DEPTH):0]   prog_len,
  output logic                          overflow,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_raddr,
  output logic [BUS_TO_CORE-1:0]        imem_rdata,
  input  logic                          core_done
);
  import sched_pkg::*;

  localparam int BEAT_N = FRAME_SIZE / BUS_TO_CORE;
  localparam int AW     = $clog2(IMEM_DEPTH);
  localparam int BW     = $clog2(BEAT_N);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(IMEM_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEAT_N - 1);

  rx_state_t     state, state_nxt;
  logic [AW:0]   wr_ptr;
  logic [BW-1:0] beat_cnt;
  logic          acc, room, wr_en, frame_end, done_seen;

  // Handshakes decode only the state register, never frame_valid.
  assign core_reading = (state == IDLE) || (state == RECV);
  assign core_ready   = (state == IDLE) || (state == RECV);
  assign prog_start   = (state == LAUNCH);

  assign acc       = frame_valid & frame_mask[CORE_ID] & core_reading;
  assign room      = wr_ptr < DEPTH_W;
  assign wr_en     = acc & room;
  assign frame_end = acc && (beat_cnt == LAST_BEAT) && frame_last;
  assign done_seen = (state == RUN) && core_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RECV: begin
        if (frame_end)  state_nxt = LAUNCH;
        else if (acc)   state_nxt = RECV;
      end
      LAUNCH:           state_nxt = RUN;
      RUN:    if (core_done) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
      prog_len <= '0;
    end else begin
      if (done_seen) begin
        wr_ptr   <= '0;
        beat_cnt <= '0;
      end else if (acc) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
        if (room) wr_ptr <= wr_ptr + (AW+1)'(1);
        // The first beat of a task clears the previous task's overflow.
        overflow <= (state == IDLE) ? !room : (overflow | !room);
      end
      // wr_ptr saturates, so this is already min(total beats, IMEM_DEPTH).
      if (frame_end) prog_len <= wr_ptr + (AW+1)'(wr_en);
    end
  end

  core_imem #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (BUS_TO_CORE)
  ) u_imem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (frame_data),
    .raddr (imem_raddr),
    .rdata (imem_rdata)
  );
endmodule
